// File: rtl/mem_tx_arbiter.sv
// mem_tx_arbiter
//   Shares the serial memory interface between requester 0 (scheduler, high
//   priority) and requester 1 (prefetcher, low priority). TX ownership is held
//   for a whole transaction. r0_reserve keeps the channel between transactions.
//   A routing FIFO remembers who issued each outstanding read, so RX strobes
//   reach the right requester.
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     When defined, r1 is granted after STARVE_LIMIT lost arbitrations,
//     unless r0_reserve is set.
//
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     r0_* / r1_*  (inputs)           requester commands, payloads, reserve
//     m_cmd_valid, m_cmd, m_data      muxed command towards memory_interface
//     m_cmd_started, m_tx_*           TX strobes from memory_interface
//     m_rx_*                          RX strobes from memory_interface
//     owner                           current (effective) TX owner, 1 = r1
//     r0_/r1_ started/data_next/tx_done   TX strobes gated to the owner
//     r0_/r1_ rx_started/rx_valid/rx_done RX strobes routed by the FIFO head
//     outstanding, full               routing FIFO occupancy
//     rx_error                        sticky: m_rx_done with an empty FIFO
module mem_tx_arbiter #(
    parameter int                  IO_BITS         = 2,
    parameter int                  CMD_BITS        = 3,
    parameter logic [CMD_BITS-1:0] READ_CMD        = CMD_BITS'(1),
    parameter int                  MAX_OUTSTANDING = 4,
    parameter int                  STARVE_LIMIT    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                r0_cmd_valid,
    input  logic [CMD_BITS-1:0] r0_cmd,
    input  logic [IO_BITS-1:0]  r0_data,
    input  logic                r0_reply_wanted,
    input  logic                r0_reserve,
    input  logic                r1_cmd_valid,
    input  logic [CMD_BITS-1:0] r1_cmd,
    input  logic [IO_BITS-1:0]  r1_data,
    output logic                m_cmd_valid,
    output logic [CMD_BITS-1:0] m_cmd,
    output logic [IO_BITS-1:0]  m_data,
    input  logic                m_cmd_started,
    input  logic                m_tx_active,
    input  logic                m_tx_data_next,
    input  logic                m_tx_done,
    input  logic                m_rx_started,
    input  logic                m_rx_data_valid,
    input  logic                m_rx_done,
    output logic                owner,
    output logic                r0_started,
    output logic                r0_data_next,
    output logic                r0_tx_done,
    output logic                r1_started,
    output logic                r1_data_next,
    output logic                r1_tx_done,
    output logic                r0_rx_started,
    output logic                r0_rx_valid,
    output logic                r0_rx_done,
    output logic                r1_rx_started,
    output logic                r1_rx_valid,
    output logic                r1_rx_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                full,
    output logic                rx_error
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {OWN_R0 = 1'b0, OWN_R1 = 1'b1} owner_e;

    owner_e owner_q;
    owner_e arb_owner;
    owner_e eff_owner;
    logic   want0;
    logic   sel_r1;
    logic   sel_valid;

    assign want0 = r0_cmd_valid | r0_reserve;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt >= SW'(STARVE_LIMIT)) & r1_cmd_valid & ~r0_reserve;

    always_comb begin
        arb_owner = OWN_R0;
        if (starved || !want0)
            arb_owner = OWN_R1;
    end

    // Counts lost arbitrations of a waiting r1; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!m_tx_active) begin
            if (arb_owner == OWN_R1)
                starve_cnt <= '0;
            else if (r1_cmd_valid && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        arb_owner = OWN_R1;
        if (want0)
            arb_owner = OWN_R0;
    end
`endif

    // Ownership is frozen while a transaction runs. Between transactions,
    // arbitration is combinational, so a new request is muxed through at once.
    always_ff @(posedge clk) begin
        if (reset)
            owner_q <= OWN_R1;
        else if (!m_tx_active)
            owner_q <= arb_owner;
    end

    assign eff_owner = m_tx_active ? owner_q : arb_owner;
    assign sel_r1    = (eff_owner == OWN_R1);
    assign owner     = sel_r1;

    assign m_cmd     = sel_r1 ? r1_cmd  : r0_cmd;
    assign m_data    = sel_r1 ? r1_data : r0_data;
    assign sel_valid = sel_r1 ? r1_cmd_valid : r0_cmd_valid;
    // When full, only reads are held back, because they need a routing slot.
    assign m_cmd_valid = sel_valid & ~(full & (m_cmd == READ_CMD));

    assign r0_started   = m_cmd_started  & ~sel_r1;
    assign r0_data_next = m_tx_data_next & ~sel_r1;
    assign r0_tx_done   = m_tx_done      & ~sel_r1;
    assign r1_started   = m_cmd_started  &  sel_r1;
    assign r1_data_next = m_tx_data_next &  sel_r1;
    assign r1_tx_done   = m_tx_done      &  sel_r1;

    // Routing FIFO: one {reply, src} entry per outstanding read.
    logic [MAX_OUTSTANDING-1:0] fifo_reply;
    logic [MAX_OUTSTANDING-1:0] fifo_src;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [CNT_W-1:0]           count;
    logic                       empty;
    logic                       push_req;
    logic                       push;
    logic                       pop;
    logic                       head_live;
    logic                       head_src;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(MAX_OUTSTANDING));
    assign push_req = m_cmd_started & (m_cmd == READ_CMD);
    assign pop      = m_rx_done & ~empty;
    // A push into a full FIFO is only accepted alongside a pop.
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rx_error <= 1'b0;
        end else begin
            if (push) begin
                fifo_reply[wr_ptr] <= sel_r1 | r0_reply_wanted;
                fifo_src[wr_ptr]   <= sel_r1;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (m_rx_done && empty)
                rx_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push_req && full && !pop));
    end

    assign outstanding = count;
    assign head_live   = ~empty & fifo_reply[rd_ptr];
    assign head_src    = fifo_src[rd_ptr];

    assign r0_rx_started = m_rx_started    & head_live & ~head_src;
    assign r0_rx_valid   = m_rx_data_valid & head_live & ~head_src;
    assign r0_rx_done    = m_rx_done       & head_live & ~head_src;
    assign r1_rx_started = m_rx_started    & head_live &  head_src;
    assign r1_rx_valid   = m_rx_data_valid & head_live &  head_src;
    assign r1_rx_done    = m_rx_done       & head_live &  head_src;

endmodule

// File: tb/tb_mem_tx_arbiter.sv
module tb_mem_tx_arbiter;

    localparam int         MAXO = 4;
    localparam logic [2:0] READ = 3'd1;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_cmd_valid, r0_reply_wanted, r0_reserve, r1_cmd_valid;
    logic [2:0] r0_cmd, r1_cmd, m_cmd;
    logic [1:0] r0_data, r1_data, m_data;
    logic       m_cmd_valid, m_cmd_started, m_tx_active, m_tx_data_next, m_tx_done;
    logic       m_rx_started, m_rx_data_valid, m_rx_done;
    logic       owner;
    logic       r0_started, r0_data_next, r0_tx_done, r1_started, r1_data_next, r1_tx_done;
    logic       r0_rx_started, r0_rx_valid, r0_rx_done, r1_rx_started, r1_rx_valid, r1_rx_done;
    logic [2:0] outstanding;
    logic       full, rx_error;

    mem_tx_arbiter #(
        .IO_BITS(2), .CMD_BITS(3), .READ_CMD(3'd1), .MAX_OUTSTANDING(4), .STARVE_LIMIT(7)
    ) dut (
        .clk(clk), .reset(reset),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd(r0_cmd), .r0_data(r0_data),
        .r0_reply_wanted(r0_reply_wanted), .r0_reserve(r0_reserve),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd(r1_cmd), .r1_data(r1_data),
        .m_cmd_valid(m_cmd_valid), .m_cmd(m_cmd), .m_data(m_data),
        .m_cmd_started(m_cmd_started), .m_tx_active(m_tx_active),
        .m_tx_data_next(m_tx_data_next), .m_tx_done(m_tx_done),
        .m_rx_started(m_rx_started), .m_rx_data_valid(m_rx_data_valid), .m_rx_done(m_rx_done),
        .owner(owner),
        .r0_started(r0_started), .r0_data_next(r0_data_next), .r0_tx_done(r0_tx_done),
        .r1_started(r1_started), .r1_data_next(r1_data_next), .r1_tx_done(r1_tx_done),
        .r0_rx_started(r0_rx_started), .r0_rx_valid(r0_rx_valid), .r0_rx_done(r0_rx_done),
        .r1_rx_started(r1_rx_started), .r1_rx_valid(r1_rx_valid), .r1_rx_done(r1_rx_done),
        .outstanding(outstanding), .full(full), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: the ownership bit, a queue of {reply, src} entries, and the error flag.
    bit       mown = 1'b1;
    bit [1:0] mq[$];
    bit       merr = 1'b0;

    function automatic logic [23:0] model_out();
        logic       want0, eff, v, fl;
        logic [2:0] c;
        logic [1:0] d;
        logic [5:0] rx;
        want0 = r0_cmd_valid | r0_reserve;
        eff   = m_tx_active ? mown : !want0;
        c     = eff ? r1_cmd : r0_cmd;
        d     = eff ? r1_data : r0_data;
        fl    = (mq.size() == MAXO);
        v     = (eff ? r1_cmd_valid : r0_cmd_valid) && !(fl && c == READ);
        rx    = '0;
        if (mq.size() > 0 && mq[0][1]) begin
            if (mq[0][0]) rx[2:0] = {m_rx_started, m_rx_data_valid, m_rx_done};
            else          rx[5:3] = {m_rx_started, m_rx_data_valid, m_rx_done};
        end
        return {v, c, d, eff,
                !eff & m_cmd_started, !eff & m_tx_data_next, !eff & m_tx_done,
                eff & m_cmd_started, eff & m_tx_data_next, eff & m_tx_done,
                rx, 3'(mq.size()), fl, merr};
    endfunction

    function automatic void model_commit();
        logic want0, eff;
        if (reset) begin
            mown = 1'b1;
            mq.delete();
            merr = 1'b0;
            return;
        end
        want0 = r0_cmd_valid | r0_reserve;
        eff   = m_tx_active ? mown : !want0;
        if (m_rx_done && mq.size() == 0) merr = 1'b1;
        if (m_rx_done && mq.size() > 0) void'(mq.pop_front());
        if (m_cmd_started && (eff ? r1_cmd : r0_cmd) == READ && mq.size() < MAXO)
            mq.push_back({eff ? 1'b1 : r0_reply_wanted, eff});
        if (!m_tx_active) mown = !want0;
    endfunction

    function automatic logic [23:0] dut_out();
        return {m_cmd_valid, m_cmd, m_data, owner,
                r0_started, r0_data_next, r0_tx_done, r1_started, r1_data_next, r1_tx_done,
                r0_rx_started, r0_rx_valid, r0_rx_done, r1_rx_started, r1_rx_valid, r1_rx_done,
                outstanding, full, rx_error};
    endfunction

    function automatic logic [13:0] dut_short();
        return {m_cmd_valid, owner, r0_started, r1_started,
                r0_rx_started, r0_rx_valid, r0_rx_done, r1_rx_started, r1_rx_valid, r1_rx_done,
                outstanding, full};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    typedef struct {
        bit r0v; bit [2:0] r0c; bit rw; bit res;
        bit r1v; bit [2:0] r1c;
        bit act; bit st; bit rxs; bit rxv; bit rxd;
        bit [13:0] exp;   // {valid, owner, r0_started, r1_started, rx[5:0], outstanding, full}
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit r0v, bit [2:0] r0c, bit rw, bit res, bit r1v, bit [2:0] r1c,
                                bit act, bit st, bit rxs, bit rxv, bit rxd,
                                bit ev, bit eo, bit es0, bit es1, bit [5:0] erx,
                                bit [2:0] eout, bit efull);
        vec_t v;
        v.r0v = r0v; v.r0c = r0c; v.rw = rw; v.res = res; v.r1v = r1v; v.r1c = r1c;
        v.act = act; v.st = st; v.rxs = rxs; v.rxv = rxv; v.rxd = rxd;
        v.exp = {ev, eo, es0, es1, erx, eout, efull};
        tv.push_back(v);
    endfunction

    task automatic idle_inputs();
        r0_cmd_valid = 0; r0_cmd = 0; r0_reply_wanted = 0; r0_reserve = 0; r0_data = 2'b01;
        r1_cmd_valid = 0; r1_cmd = 0; r1_data = 2'b10;
        m_cmd_started = 0; m_tx_active = 0; m_tx_data_next = 0; m_tx_done = 0;
        m_rx_started = 0; m_rx_data_valid = 0; m_rx_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] e;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("reset_state", 32'(dut_short()), 32'(14'b0_1_0_0_000000_000_0));
        check("reset_rx_error", 32'(rx_error), 32'd0);

        // Arbitration with simultaneous requests, then routing of two replies
        add(1,1,1,0, 1,1, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 0,0);
        add(0,0,0,0, 1,1, 1,0, 0,0,0, 0,0,0,0, 6'b000000, 1,0);
        add(0,0,0,0, 1,1, 0,1, 0,0,0, 1,1,0,1, 6'b000000, 1,0);
        add(0,0,0,0, 0,0, 1,0, 1,0,0, 0,1,0,0, 6'b100000, 2,0);
        add(0,0,0,0, 0,0, 1,0, 0,1,0, 0,1,0,0, 6'b010000, 2,0);
        add(0,0,0,0, 0,0, 0,0, 0,0,1, 0,1,0,0, 6'b001000, 2,0);
        add(0,0,0,0, 0,0, 0,0, 1,0,1, 0,1,0,0, 6'b000101, 1,0);
        // r1 fills the FIFO; the 5th read is blocked; an r0 write still passes
        for (int k = 0; k < 4; k++)
            add(0,0,0,0, 1,1, 0,1, 0,0,0, 1,1,0,1, 6'b000000, 3'(k),0);
        add(0,0,0,0, 1,1, 0,0, 0,0,0, 0,1,0,0, 6'b000000, 4,1);
        add(1,2,0,0, 1,1, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 4,1);
        add(0,0,0,0, 0,0, 0,0, 0,0,1, 0,1,0,0, 6'b000001, 4,1);
        add(0,0,0,0, 0,0, 0,0, 0,0,0, 0,1,0,0, 6'b000000, 3,0);
        for (int k = 3; k > 0; k--)
            add(0,0,0,0, 0,0, 0,0, 0,0,1, 0,1,0,0, 6'b000001, 3'(k),0);
        add(0,0,0,0, 0,0, 0,0, 0,0,0, 0,1,0,0, 6'b000000, 0,0);
        // Interleaved r0 (reply), r1, r0 (no reply)
        add(1,1,1,0, 0,0, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 0,0);
        add(0,0,0,0, 1,1, 0,1, 0,0,0, 1,1,0,1, 6'b000000, 1,0);
        add(1,1,0,0, 0,0, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 2,0);
        add(0,0,0,0, 0,0, 0,0, 1,1,1, 0,1,0,0, 6'b111000, 3,0);
        add(0,0,0,0, 0,0, 0,0, 1,1,1, 0,1,0,0, 6'b000111, 2,0);
        add(0,0,0,0, 0,0, 0,0, 1,1,1, 0,1,0,0, 6'b000000, 1,0);
        add(0,0,0,0, 0,0, 0,0, 0,0,0, 0,1,0,0, 6'b000000, 0,0);
        // Reserve held across a read and a write while r1 waits
        add(1,1,1,1, 1,1, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 0,0);
        add(0,0,0,1, 1,1, 1,0, 0,0,0, 0,0,0,0, 6'b000000, 1,0);
        add(0,0,0,1, 1,1, 0,0, 0,0,0, 0,0,0,0, 6'b000000, 1,0);
        add(1,2,0,1, 1,1, 0,1, 0,0,0, 1,0,1,0, 6'b000000, 1,0);
        add(0,0,0,1, 1,1, 1,0, 0,0,0, 0,0,0,0, 6'b000000, 1,0);
        add(0,0,0,0, 1,2, 0,1, 0,0,0, 1,1,0,1, 6'b000000, 1,0);
        add(0,0,0,0, 0,0, 0,0, 0,0,1, 0,1,0,0, 6'b001000, 1,0);

        foreach (tv[i]) begin
            idle_inputs();
            r0_cmd_valid = tv[i].r0v; r0_cmd = tv[i].r0c; r0_reply_wanted = tv[i].rw;
            r0_reserve = tv[i].res; r1_cmd_valid = tv[i].r1v; r1_cmd = tv[i].r1c;
            m_tx_active = tv[i].act; m_cmd_started = tv[i].st;
            m_rx_started = tv[i].rxs; m_rx_data_valid = tv[i].rxv; m_rx_done = tv[i].rxd;
            #1;
            check($sformatf("vec%0d", i), 32'(dut_short()), 32'(tv[i].exp));
            tick();
        end

        // RX done with empty FIFO: strobes dropped, rx_error sticks
        idle_inputs();
        m_rx_done = 1;
        #1;
        check("empty_rx_dropped", 32'({r0_rx_done, r1_rx_done, rx_error}), 32'd0);
        tick();
        m_rx_done = 0;
        #1;
        check("rx_error_set", 32'(rx_error), 32'd1);
        tick();
        #1;
        check("rx_error_sticky", 32'(rx_error), 32'd1);

        // Reset in the middle of a transaction
        r1_cmd_valid = 1; r1_cmd = READ; m_cmd_started = 1;
        tick();
        m_cmd_started = 0; m_tx_active = 1; r0_cmd_valid = 1;
        #1;
        check("pre_reset_outstanding", 32'(outstanding), 32'd1);
        reset = 1;
        tick();
        reset = 0; idle_inputs();
        #1;
        check("mid_reset_outstanding", 32'(outstanding), 32'd0);
        check("mid_reset_owner", 32'(owner), 32'd1);
        check("mid_reset_rx_error", 32'(rx_error), 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            r0_cmd_valid = $urandom_range(0, 1); r0_cmd = 3'($urandom_range(0, 3));
            r0_reply_wanted = $urandom_range(0, 1); r0_reserve = ($urandom_range(0, 3) == 0);
            r0_data = 2'($urandom);
            r1_cmd_valid = $urandom_range(0, 1); r1_cmd = 3'($urandom_range(0, 3));
            r1_data = 2'($urandom);
            m_tx_active = $urandom_range(0, 1);
            m_tx_data_next = $urandom_range(0, 1); m_tx_done = $urandom_range(0, 1);
            m_rx_started = $urandom_range(0, 1); m_rx_data_valid = $urandom_range(0, 1);
            m_rx_done = ($urandom_range(0, 2) == 0);
            m_cmd_started = 0;
            #1;
            e = model_out();
            m_cmd_started = e[23] & 1'($urandom_range(0, 1));
            #1;
            check($sformatf("rand%0d", n), 32'(dut_out()), 32'(model_out()));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
